// File: rtl/riscv_rf_pkg.sv
// Shared constants and state encoding for the register-file operand-read controller.
package riscv_rf_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    // x0 is hard-wired to zero and never tracked by the scoreboard.
    localparam int unsigned REG_ZERO = 0;

    typedef logic [0:0] rf_ctrl_state_e;

    localparam rf_ctrl_state_e IDLE = 1'b0;
    localparam rf_ctrl_state_e RESP = 1'b1;

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue, cleared on writeback.
module riscv_rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_en_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [ADDR_WIDTH-1:0] q1_addr_i,
    output logic                  q1_busy_o,
    input  logic [ADDR_WIDTH-1:0] q2_addr_i,
    output logic                  q2_busy_o,
    input  logic [ADDR_WIDTH-1:0] qrd_addr_i,
    output logic                  qrd_busy_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [NumRegs-1:0] busy_q, busy_d;

    // Set is applied after clear so a same-index set/clear leaves the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && (set_addr_i != ADDR_WIDTH'(REG_ZERO))) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign q1_busy_o  = busy_q[q1_addr_i];
    assign q2_busy_o  = busy_q[q2_addr_i];
    assign qrd_busy_o = busy_q[qrd_addr_i];

endmodule

// File: rtl/riscv_rf_ctrl.sv
// Operand-read controller between decode and a register file with 1-clk synchronous reads.
module riscv_rf_ctrl
    import riscv_rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_rs1_i,
    input  logic [ADDR_WIDTH-1:0] req_rs2_i,
    input  logic [ADDR_WIDTH-1:0] req_rd_i,
    input  logic                  req_rd_wen_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rs1_data_o,
    output logic [DATA_WIDTH-1:0] rsp_rs2_data_o,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  rf_rd1_en_o,
    output logic [ADDR_WIDTH-1:0] rf_rd1_addr_o,
    output logic                  rf_rd2_en_o,
    output logic [ADDR_WIDTH-1:0] rf_rd2_addr_o,
    input  logic [DATA_WIDTH-1:0] rf_rd1_data_i,
    input  logic [DATA_WIDTH-1:0] rf_rd2_data_i,
    output logic                  rf_wr_en_o,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr_o,
    output logic [DATA_WIDTH-1:0] rf_wr_data_o
);

    rf_ctrl_state_e state_q, state_d;

    logic                  zero1_q, zero1_d, zero2_q, zero2_d;
    logic                  byp1_q, byp1_d, byp2_q, byp2_d;
    logic [DATA_WIDTH-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;

    logic busy_rs1, busy_rs2, busy_rd;
    logic rs1_zero, rs2_zero, rd_zero;
    logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic hazard_rs1, hazard_rs2, hazard_rd;
    logic slot_free, accept, fire;

    riscv_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (accept && req_rd_wen_i && !rd_zero),
        .set_addr_i (req_rd_i),
        .clr_en_i   (wb_valid_i),
        .clr_addr_i (wb_addr_i),
        .q1_addr_i  (req_rs1_i),
        .q1_busy_o  (busy_rs1),
        .q2_addr_i  (req_rs2_i),
        .q2_busy_o  (busy_rs2),
        .qrd_addr_i (req_rd_i),
        .qrd_busy_o (busy_rd)
    );

    assign rs1_zero = (req_rs1_i == ADDR_WIDTH'(REG_ZERO));
    assign rs2_zero = (req_rs2_i == ADDR_WIDTH'(REG_ZERO));
    assign rd_zero  = (req_rd_i == ADDR_WIDTH'(REG_ZERO));

    // A writeback landing this cycle resolves the hazard; its data is forwarded.
    assign wb_hit_rs1 = wb_valid_i && (wb_addr_i == req_rs1_i);
    assign wb_hit_rs2 = wb_valid_i && (wb_addr_i == req_rs2_i);
    assign wb_hit_rd  = wb_valid_i && (wb_addr_i == req_rd_i);

    assign hazard_rs1 = !rs1_zero && busy_rs1 && !wb_hit_rs1;
    assign hazard_rs2 = !rs2_zero && busy_rs2 && !wb_hit_rs2;
    assign hazard_rd  = req_rd_wen_i && busy_rd && !wb_hit_rd;

    assign rsp_valid_o = (state_q == RESP);
    assign slot_free   = (state_q == IDLE) || rsp_ready_i;
    assign req_ready_o = slot_free && !hazard_rs1 && !hazard_rs2 && !hazard_rd;
    assign accept      = req_valid_i && req_ready_o;
    assign fire        = rsp_valid_o && rsp_ready_i;

    // Reads are only enabled on accept, so the RF output holds under backpressure.
    assign rf_rd1_en_o   = accept;
    assign rf_rd1_addr_o = req_rs1_i;
    assign rf_rd2_en_o   = accept;
    assign rf_rd2_addr_o = req_rs2_i;

    assign rf_wr_en_o   = wb_valid_i && (wb_addr_i != ADDR_WIDTH'(REG_ZERO));
    assign rf_wr_addr_o = wb_addr_i;
    assign rf_wr_data_o = wb_data_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (fire && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        zero1_d     = zero1_q;
        zero2_d     = zero2_q;
        byp1_d      = byp1_q;
        byp2_d      = byp2_q;
        byp1_data_d = byp1_data_q;
        byp2_data_d = byp2_data_q;
        if (accept) begin
            zero1_d = rs1_zero;
            zero2_d = rs2_zero;
            byp1_d  = wb_hit_rs1 && !rs1_zero;
            byp2_d  = wb_hit_rs2 && !rs2_zero;
            if (wb_hit_rs1) begin
                byp1_data_d = wb_data_i;
            end
            if (wb_hit_rs2) begin
                byp2_data_d = wb_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            zero1_q     <= 1'b0;
            zero2_q     <= 1'b0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp1_data_q <= '0;
            byp2_data_q <= '0;
        end else begin
            state_q     <= state_d;
            zero1_q     <= zero1_d;
            zero2_q     <= zero2_d;
            byp1_q      <= byp1_d;
            byp2_q      <= byp2_d;
            byp1_data_q <= byp1_data_d;
            byp2_data_q <= byp2_data_d;
        end
    end

    assign rsp_rs1_data_o = zero1_q ? '0 : (byp1_q ? byp1_data_q : rf_rd1_data_i);
    assign rsp_rs2_data_o = zero2_q ? '0 : (byp2_q ? byp2_data_q : rf_rd2_data_i);

endmodule
